// File: rtl/ps2_direction_decoder_pkg.sv
// Shared PS/2 scancode constants, direction encoding and prefix FSM states for the direction decoder.
// The direction codes match the encoding the processor wrapper reads at port 4100.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam logic [7:0] KEY_UP_EXT     = 8'h75;
  localparam logic [7:0] KEY_RIGHT_EXT  = 8'h74;
  localparam logic [7:0] KEY_DOWN_EXT   = 8'h72;
  localparam logic [7:0] KEY_LEFT_EXT   = 8'h6B;
  localparam logic [7:0] KEY_UP_WASD    = 8'h1D;
  localparam logic [7:0] KEY_RIGHT_WASD = 8'h23;
  localparam logic [7:0] KEY_DOWN_WASD  = 8'h1B;
  localparam logic [7:0] KEY_LEFT_WASD  = 8'h1C;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_DOWN  = 3'd3,
    DIR_LEFT  = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0
  } prefix_state_t;

  // Maps a completed scancode to a direction; WASD codes count only when enabled.
  function automatic dir_t map_code(input logic [7:0] code, input logic is_ext, input logic wasd_en);
    dir_t d;
    d = DIR_NONE;
    if (is_ext) begin
      case (code)
        KEY_UP_EXT:    d = DIR_UP;
        KEY_RIGHT_EXT: d = DIR_RIGHT;
        KEY_DOWN_EXT:  d = DIR_DOWN;
        KEY_LEFT_EXT:  d = DIR_LEFT;
        default:       d = DIR_NONE;
      endcase
    end else if (wasd_en) begin
      case (code)
        KEY_UP_WASD:    d = DIR_UP;
        KEY_RIGHT_WASD: d = DIR_RIGHT;
        KEY_DOWN_WASD:  d = DIR_DOWN;
        KEY_LEFT_WASD:  d = DIR_LEFT;
        default:        d = DIR_NONE;
      endcase
    end
    return d;
  endfunction

  // Held-bit layout is {left, down, right, up}.
  function automatic logic [3:0] dir_onehot(input dir_t d);
    logic [3:0] oh;
    case (d)
      DIR_UP:    oh = 4'b0001;
      DIR_RIGHT: oh = 4'b0010;
      DIR_DOWN:  oh = 4'b0100;
      DIR_LEFT:  oh = 4'b1000;
      default:   oh = 4'b0000;
    endcase
    return oh;
  endfunction

  function automatic dir_t pick_priority(input logic [3:0] held);
    dir_t d;
    if (held[0])      d = DIR_UP;
    else if (held[1]) d = DIR_RIGHT;
    else if (held[2]) d = DIR_DOWN;
    else if (held[3]) d = DIR_LEFT;
    else              d = DIR_NONE;
    return d;
  endfunction

endpackage

// File: rtl/ps2_direction_decoder_prefix_fsm.sv
// Byte-strobe edge detect, E0/F0 prefix tracking and prefix timeout.
// Emits a one-cycle key event in the same cycle the final byte of a code is accepted.
module ps2_prefix_fsm
  import ps2_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 50000000,
  parameter int TIMEOUT_W      = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_out,
  output logic       event_valid,
  output logic       event_is_break,
  output logic       event_is_ext,
  output logic [7:0] event_code
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(PREFIX_TIMEOUT - 1);

  prefix_state_t          state_q, state_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic                   key_q;
  logic                   accept;

  assign accept     = ps2_key_pressed & ~key_q;
  assign event_code = ps2_out;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    event_valid    = 1'b0;
    event_is_break = 1'b0;
    event_is_ext   = 1'b0;
    if (accept) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (ps2_out == PS2_EXT)      state_d = ST_GOT_E0;
          else if (ps2_out == PS2_BRK) state_d = ST_GOT_F0;
          else                         event_valid = 1'b1;
        end
        ST_GOT_E0: begin
          if (ps2_out == PS2_BRK)      state_d = ST_GOT_E0F0;
          else if (ps2_out == PS2_EXT) state_d = ST_GOT_E0;
          else begin
            event_valid  = 1'b1;
            event_is_ext = 1'b1;
            state_d      = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          event_valid    = 1'b1;
          event_is_break = 1'b1;
          state_d        = ST_IDLE;
        end
        default: begin
          event_valid    = 1'b1;
          event_is_break = 1'b1;
          event_is_ext   = 1'b1;
          state_d        = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      // A stalled prefix is dropped silently rather than completing a code.
      if (cnt_q == TIMEOUT_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + TIMEOUT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      key_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= ps2_key_pressed;
    end
  end

endmodule

// File: rtl/ps2_direction_decoder.sv
// PS/2 arrow/WASD tracker producing a one-hot-or-zero direction plus its 0..4 code.
// The most recently pressed held key wins; on its release a fixed priority picks the successor.
module ps2_direction_decoder
  import ps2_pkg::*;
#(
  parameter bit ENABLE_WASD    = 1'b1,
  parameter int PREFIX_TIMEOUT = 50000000,
  parameter int TIMEOUT_W      = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_out,
  output logic       upSig,
  output logic       rightSig,
  output logic       downSig,
  output logic       leftSig,
  output logic [2:0] dir_code,
  output logic [3:0] held
);

  logic       ev_valid, ev_break, ev_ext;
  logic [7:0] ev_code;
  dir_t       ev_dir;
  logic [3:0] ev_oh;

  logic [3:0] held_q, held_d;
  dir_t       last_q, last_d;
  logic       last_v_q, last_v_d;
  dir_t       out_dir_q, out_dir_d;
  logic [3:0] sig_q, sig_d;
  dir_t       successor;

  ps2_prefix_fsm #(
    .PREFIX_TIMEOUT (PREFIX_TIMEOUT),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_prefix (
    .clock           (clock),
    .reset           (reset),
    .ps2_key_pressed (ps2_key_pressed),
    .ps2_out         (ps2_out),
    .event_valid     (ev_valid),
    .event_is_break  (ev_break),
    .event_is_ext    (ev_ext),
    .event_code      (ev_code)
  );

  assign ev_dir = map_code(ev_code, ev_ext, ENABLE_WASD);
  assign ev_oh  = dir_onehot(ev_dir);

  always_comb begin
    held_d    = held_q;
    last_d    = last_q;
    last_v_d  = last_v_q;
    successor = DIR_NONE;
    if (ev_valid && (ev_dir != DIR_NONE)) begin
      if (!ev_break) begin
        held_d   = held_q | ev_oh;
        last_d   = ev_dir;
        last_v_d = 1'b1;
      end else begin
        held_d = held_q & ~ev_oh;
        if (last_q == ev_dir) begin
          successor = pick_priority(held_d);
          if (successor == DIR_NONE) begin
            last_v_d = 1'b0;
          end else begin
            last_d = successor;
          end
        end
      end
    end
  end

  // Outputs derive from a single direction value, so they are one-hot-or-zero by construction.
  always_comb begin
    out_dir_d = last_v_q ? last_q : DIR_NONE;
    sig_d     = dir_onehot(out_dir_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      held_q    <= 4'b0000;
      last_q    <= DIR_NONE;
      last_v_q  <= 1'b0;
      out_dir_q <= DIR_NONE;
      sig_q     <= 4'b0000;
    end else begin
      held_q    <= held_d;
      last_q    <= last_d;
      last_v_q  <= last_v_d;
      out_dir_q <= out_dir_d;
      sig_q     <= sig_d;
    end
  end

  assign upSig    = sig_q[0];
  assign rightSig = sig_q[1];
  assign downSig  = sig_q[2];
  assign leftSig  = sig_q[3];
  assign dir_code = out_dir_q;
  assign held     = held_q;

endmodule
